// File: rtl/div_dispatch.sv
// div_dispatch: credit-limited front end for a fixed-latency 24.8 divider.
// Tags ride a shadow pipeline; results queue in an in-order FWFT FIFO.
module div_dispatch #(
    parameter int FIFO_DEPTH  = 16,
    parameter int TAG_W       = 4,
    parameter int DIV_LATENCY = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [TAG_W-1:0] req_tag,
    input  logic [31:0]      req_num,
    input  logic [31:0]      req_den,
    output logic             div_valid,
    output logic [39:0]      div_dividend,
    output logic [31:0]      div_divisor,
    input  logic             div_quo_valid,
    input  logic [39:0]      div_quo_data,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [TAG_W-1:0] rsp_tag,
    output logic [39:0]      rsp_quo,
    output logic             rsp_dz,
    output logic             err
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int LL = DIV_LATENCY - 1;

    logic [CW-1:0] occ;
    logic          accept;
    logic          pop;

    logic [31:0]      iss_num;
    logic [31:0]      iss_den;
    logic [TAG_W-1:0] iss_tag;

    logic [DIV_LATENCY-1:0] pv;
    logic [TAG_W-1:0]       ptag [DIV_LATENCY];
    logic                   pdz  [DIV_LATENCY];
    logic                   psgn [DIV_LATENCY];

    logic [TAG_W-1:0] mem_tag [FIFO_DEPTH];
    logic [39:0]      mem_quo [FIFO_DEPTH];
    logic             mem_dz  [FIFO_DEPTH];
    logic [PW-1:0]    wp;
    logic [PW-1:0]    rp;
    logic [CW-1:0]    cnt;
    logic             wr;
    logic [39:0]      wq;

    assign req_ready = (occ < CW'(FIFO_DEPTH));
    assign accept    = req_valid & req_ready;
    assign pop       = rsp_valid & rsp_ready;

    // Credit count: every accepted request until its response is popped
    always_ff @(posedge clk) begin
        if (!reset) begin
            occ <= '0;
        end else begin
            case ({accept, pop})
                2'b10:   occ <= occ + CW'(1);
                2'b01:   occ <= occ - CW'(1);
                default: occ <= occ;
            endcase
        end
    end

    // Issue register: one-cycle divider launch after each accept
    always_ff @(posedge clk) begin
        if (!reset) begin
            div_valid <= 1'b0;
            iss_num   <= '0;
            iss_den   <= '0;
            iss_tag   <= '0;
        end else begin
            div_valid <= accept;
            if (accept) begin
                iss_num <= req_num;
                iss_den <= req_den;
                iss_tag <= req_tag;
            end
        end
    end

    assign div_dividend = {iss_num, 8'h00};
    assign div_divisor  = iss_den;

    // Shadow pipeline valid bits, aligned with the divider latency
    always_ff @(posedge clk) begin
        if (!reset) begin
            pv <= '0;
        end else begin
            pv[0] <= div_valid;
            for (int i = 1; i < DIV_LATENCY; i++) begin
                pv[i] <= pv[i-1];
            end
        end
    end

    // Shadow pipeline payload: tag, divide-by-zero and numerator sign
    always_ff @(posedge clk) begin
        ptag[0] <= iss_tag;
        pdz[0]  <= (iss_den == 32'd0);
        psgn[0] <= iss_num[31];
        for (int i = 1; i < DIV_LATENCY; i++) begin
            ptag[i] <= ptag[i-1];
            pdz[i]  <= pdz[i-1];
            psgn[i] <= psgn[i-1];
        end
    end

    // Divide-by-zero saturates toward the numerator's sign
    always_comb begin
        wq = div_quo_data;
        if (pdz[LL]) begin
            wq = psgn[LL] ? 40'h80_0000_0000 : 40'h7F_FFFF_FFFF;
        end
    end

    assign wr = div_quo_valid & pv[LL];

    // Sticky flag when divider output and shadow pipeline disagree
    always_ff @(posedge clk) begin
        if (!reset) begin
            err <= 1'b0;
        end else if (div_quo_valid != pv[LL]) begin
            err <= 1'b1;
        end
    end

    // FIFO storage; no reset needed since reads are masked when empty
    always_ff @(posedge clk) begin
        if (wr) begin
            mem_tag[wp] <= ptag[LL];
            mem_quo[wp] <= wq;
            mem_dz[wp]  <= pdz[LL];
        end
    end

    // FIFO pointers and fill count
    always_ff @(posedge clk) begin
        if (!reset) begin
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
        end else begin
            if (wr) begin
                wp <= wp + PW'(1);
            end
            if (pop) begin
                rp <= rp + PW'(1);
            end
            case ({wr, pop})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    assign rsp_valid = (cnt != '0);
    assign rsp_tag   = rsp_valid ? mem_tag[rp] : '0;
    assign rsp_quo   = rsp_valid ? mem_quo[rp] : '0;
    assign rsp_dz    = rsp_valid ? mem_dz[rp]  : 1'b0;

endmodule

// File: tb/tb_div_dispatch.sv
// tb_div_dispatch: scoreboard bench with an exact 8-cycle divider model.
// Expected responses are computed from num/den with plain integer math.
module tb_div_dispatch;

    localparam int DEPTH = 16;
    localparam int TW    = 4;
    localparam int LAT   = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          req_valid;
    logic          req_ready;
    logic [TW-1:0] req_tag;
    logic [31:0]   req_num;
    logic [31:0]   req_den;
    logic          div_valid;
    logic [39:0]   div_dividend;
    logic [31:0]   div_divisor;
    logic          div_quo_valid;
    logic [39:0]   div_quo_data;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [TW-1:0] rsp_tag;
    logic [39:0]   rsp_quo;
    logic          rsp_dz;
    logic          err;
    logic          inject;

    always #5 clk = ~clk;

    div_dispatch #(
        .FIFO_DEPTH(DEPTH),
        .TAG_W(TW),
        .DIV_LATENCY(LAT)
    ) dut (
        .clk(clk),
        .reset(reset),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_tag(req_tag),
        .req_num(req_num),
        .req_den(req_den),
        .div_valid(div_valid),
        .div_dividend(div_dividend),
        .div_divisor(div_divisor),
        .div_quo_valid(div_quo_valid),
        .div_quo_data(div_quo_data),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_tag(rsp_tag),
        .rsp_quo(rsp_quo),
        .rsp_dz(rsp_dz),
        .err(err)
    );

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;
    int acc_cyc = 0;
    int max_occ = 0;

    typedef struct {
        logic [TW-1:0] tag;
        logic [39:0]   quo;
        logic          dz;
    } exp_t;
    exp_t sbq[$];

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    // Exact signed division, as the external divider would compute it
    function automatic logic [39:0] exact(input logic [39:0] a,
                                          input logic [31:0] b);
        longint sa;
        longint sb;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (sb == 0) return '0;
        return 40'(sa / sb);
    endfunction

    // Reference: 24.8 quotient from the raw request operands
    function automatic logic [39:0] ref_quo(input logic [31:0] n,
                                            input logic [31:0] d);
        longint sn;
        longint sd;
        if (d == 0) return n[31] ? 40'h80_0000_0000 : 40'h7F_FFFF_FFFF;
        sn = longint'($signed(n));
        sd = longint'($signed(d));
        return 40'((sn * 256) / sd);
    endfunction

    logic        dv_v [LAT];
    logic [39:0] dv_q [LAT];

    assign div_quo_valid = dv_v[LAT-1] | inject;
    assign div_quo_data  = dv_q[LAT-1];

    always @(posedge clk) cyc <= cyc + 1;

    // Divider model: fixed 8-cycle pipeline sharing the DUT reset
    always @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < LAT; i++) dv_v[i] <= 1'b0;
        end else begin
            dv_v[0] <= div_valid;
            dv_q[0] <= exact(div_dividend, div_divisor);
            for (int i = 1; i < LAT; i++) begin
                dv_v[i] <= dv_v[i-1];
                dv_q[i] <= dv_q[i-1];
            end
        end
    end

    logic        hold_v = 1'b0;
    logic [44:0] hold_d;

    // Monitor: credit check, hold stability, pop-and-compare, push on accept
    always @(negedge clk) begin
        exp_t e;
        if (!reset) begin
            sbq.delete();
            hold_v = 1'b0;
        end else begin
            chk("req_ready", req_ready, sbq.size() < DEPTH);
            if (hold_v)
                chk("rsp_hold", {rsp_valid, rsp_tag, rsp_quo, rsp_dz},
                    {1'b1, hold_d});
            hold_v = rsp_valid && !rsp_ready;
            hold_d = {rsp_tag, rsp_quo, rsp_dz};
            if (rsp_valid && rsp_ready) begin
                if (sbq.size() == 0) begin
                    chk("stale_rsp", {rsp_tag, rsp_quo}, 0);
                end else begin
                    e = sbq.pop_front();
                    chk("rsp_tag", rsp_tag, e.tag);
                    chk("rsp_quo", rsp_quo, e.quo);
                    chk("rsp_dz", rsp_dz, e.dz);
                end
            end
            if (req_valid && req_ready) begin
                e.tag = req_tag;
                e.quo = ref_quo(req_num, req_den);
                e.dz  = (req_den == 0);
                sbq.push_back(e);
                acc_cyc = cyc;
            end
            if (sbq.size() > max_occ) max_occ = sbq.size();
        end
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [TW-1:0] t, input logic [31:0] n,
                         input logic [31:0] d);
        int g = 0;
        req_valid = 1'b1;
        req_tag   = t;
        req_num   = n;
        req_den   = d;
        @(negedge clk);
        while (!req_ready && g < 200) begin
            @(negedge clk);
            g++;
        end
        if (g >= 200) chk("issue_wait", req_ready, 1);
        step();
        req_valid = 1'b0;
    endtask

    task automatic drain;
        int g = 0;
        rsp_ready = 1'b1;
        while ((sbq.size() != 0 || rsp_valid) && g < 300) begin
            step();
            g++;
        end
        if (g >= 300) chk("drain", sbq.size(), 0);
    endtask

    function automatic logic [31:0] rnd_den;
        int unsigned r;
        logic [31:0] v;
        r = $urandom_range(0, 15);
        if (r == 0) return 32'd0;
        if (r < 9) begin
            v = 32'($urandom_range(1, 4096));
            return $urandom_range(0, 1) ? -v : v;
        end
        v = $urandom;
        return (v == 0) ? 32'd1 : v;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int g;
        int stale;
        logic done;
        logic [31:0] n;
        req_valid = 1'b0;
        req_tag   = '0;
        req_num   = '0;
        req_den   = '0;
        rsp_ready = 1'b0;
        inject    = 1'b0;
        reset     = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready", req_ready, 1);
        chk("rst_div_valid", div_valid, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_err", err, 0);
        chk("rst_rsp_data", {rsp_tag, rsp_quo, rsp_dz}, 0);
        step();
        reset = 1'b1;
        step();

        // 6.0 / 2.0 with latency measurement
        rsp_ready = 1'b1;
        issue(4'd3, 32'h600, 32'h200);
        g = 0;
        @(negedge clk);
        while (!rsp_valid && g < 50) begin
            @(negedge clk);
            g++;
        end
        chk("latency", cyc - acc_cyc, 10);
        chk("quo_6_2", rsp_quo, 40'h300);
        chk("tag_6_2", rsp_tag, 3);
        step();
        drain();

        // Divide by zero saturation, both signs
        issue(4'd5, 32'hFFFF_FA00, 32'd0);
        issue(4'd6, 32'h0000_0100, 32'd0);
        g = 0;
        @(negedge clk);
        while (!rsp_valid && g < 50) begin
            @(negedge clk);
            g++;
        end
        chk("dz_neg_quo", rsp_quo, 40'h80_0000_0000);
        chk("dz_neg_flag", rsp_dz, 1);
        @(negedge clk);
        chk("dz_pos_quo", rsp_quo, 40'h7F_FFFF_FFFF);
        chk("dz_pos_flag", rsp_dz, 1);
        step();
        drain();

        // Fill all credits with the response side stalled
        rsp_ready = 1'b0;
        for (int t = 0; t < 16; t++)
            issue(4'(t), $urandom, 32'($urandom_range(1, 1000)));
        @(negedge clk);
        chk("full_ready", req_ready, 0);
        repeat (12) step();
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("first_pop_valid", rsp_valid, 1);
        chk("first_pop_tag", rsp_tag, 0);
        chk("first_pop_ready", req_ready, 0);
        @(negedge clk);
        chk("ready_after_pop", req_ready, 1);
        step();
        drain();

        // Random traffic with stalls on both sides
        done = 1'b0;
        max_occ = 0;
        fork
            begin
                for (int i = 0; i < 1000; i++) begin
                    if ($urandom_range(0, 3) == 0)
                        repeat ($urandom_range(1, 3)) step();
                    n = $urandom_range(0, 1) ? $urandom
                                             : 32'($urandom_range(0, 65535));
                    issue(4'($urandom), n, rnd_den());
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    rsp_ready = ($urandom_range(0, 3) != 0);
                    step();
                end
            end
        join
        drain();
        chk("max_occ_le_16", max_occ <= DEPTH, 1);
        chk("rand_err", err, 0);

        // Spurious divider result with nothing in flight
        step();
        inject = 1'b1;
        step();
        inject = 1'b0;
        @(negedge clk);
        chk("inject_err", err, 1);
        chk("inject_no_write", rsp_valid, 0);
        repeat (5) step();
        @(negedge clk);
        chk("inject_err_sticky", err, 1);
        chk("inject_no_write2", rsp_valid, 0);
        step();

        // Reset with five requests in flight
        rsp_ready = 1'b0;
        for (int t = 0; t < 5; t++)
            issue(4'(t + 8), $urandom, 32'($urandom_range(1, 500)));
        reset = 1'b0;
        repeat (2) step();
        reset = 1'b1;
        @(negedge clk);
        chk("post_rst_rsp_valid", rsp_valid, 0);
        chk("post_rst_req_ready", req_ready, 1);
        chk("post_rst_err", err, 0);
        step();
        rsp_ready = 1'b1;
        stale = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (rsp_valid) stale++;
        end
        chk("no_stale", stale, 0);
        step();
        issue(4'd9, 32'hFFFF_F400, 32'h400);
        drain();
        chk("final_err", err, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
